hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Producer-side hazard control for the 5-stage pipeline; operand forwarding is the consumer side.
//  Detects load-use hazards between ID/EX and IF/ID, and inserts bubbles for the required
//  number of cycles. Squashes wrong-path instructions on taken branches resolved in EX, and
//  freezes the whole pipeline while data memory is busy. Sits between the ID-stage decoder,
//  the PC/IFID/IDEX registers, and the data-memory handshake. Keeps saturating stall/flush counters.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (>=1)
//  FLUSH_CYCLES       1   cycles IF/ID + ID/EX are squashed per taken branch (>=1)
//  CNT_W              16  width of performance counters
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  IDEX_MemRead   in   1      instruction in EX is a load
//  IDEX_rd        in   5      destination reg of instruction in EX
//  IFID_rs1       in   5      source 1 of instruction in ID
//  IFID_rs2       in   5      source 2 of instruction in ID
//  IFID_use_rs1   in   1      ID instruction actually reads rs1
//  IFID_use_rs2   in   1      ID instruction actually reads rs2
//  branch_taken   in   1      taken branch/jump resolved in EX this cycle
//  dmem_busy      in   1      data memory not ready; pipeline must hold
//  PC_write       out  1      1 = PC may update
//  IFID_write     out  1      1 = IF/ID register may load
//  IFID_flush     out  1      1 = IF/ID loads a NOP
//  IDEX_bubble    out  1      1 = ID/EX control fields zeroed
//  pipe_freeze    out  1      1 = EX/MEM and MEM/WB hold
//  stall_count    out  CNT_W  load-use bubble cycles since reset
//  flush_count    out  CNT_W  taken-branch events since reset
// BEHAVIOUR
//  load_use = IDEX_MemRead & IDEX_rd!=0 & ((use_rs1 & rd==rs1) | (use_rs2 & rd==rs2)).
//  States: RUN, STALL, FLUSH. A down-counter cnt (width clog2 of max param) holds remaining cycles.
//  Control outputs are Mealy combinational, so a hazard is acted on in its detection cycle.
//  Defaults: PC_write=1, IFID_write=1, flush=0, bubble=0, freeze=0.
//  Priority in every state: dmem_busy > branch_taken > load_use / state hold.
//  dmem_busy=1: PC_write=0, IFID_write=0, freeze=1, bubble=0, flush=0.
//    In this case state, cnt and counters are unchanged. Busy takes precedence over branch_taken.
//  RUN, branch_taken: flush=1, bubble=1, PC_write=1; flush_count++.
//    FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
//  RUN, load_use (no branch): PC_write=0, IFID_write=0, bubble=1; stall_count++.
//    LOAD_STALL_CYCLES>1 -> STALL, cnt=LOAD_STALL_CYCLES-1.
//  STALL: same outputs as a load-use stall; stall_count++; cnt--.
//    cnt==1 -> RUN. The ID instruction is then re-evaluated in RUN.
//  STALL, branch_taken: protocol violation, handled deterministically.
//    Flush outputs, flush_count++, cnt=0, -> RUN (or FLUSH if FLUSH_CYCLES>1).
//  FLUSH: flush=1, bubble=1; cnt--; cnt==1 -> RUN. load_use is ignored in FLUSH.
//  Counters saturate at all-ones and never wrap.
//  Reset (async assert, sync-safe deassert): state=RUN, cnt=0, both counters=0.
//    While rst_n=0, control outputs are forced to their defaults.
//  Reset mid-STALL/FLUSH aborts the operation immediately.
// STRUCTURE
//  Shared pipeline_pkg holds:
//    state encoding (HZ_RUN=2'd0, HZ_STALL=2'd1, HZ_FLUSH=2'd2)
//    REG_ZERO=5'd0
//    NOP instruction constant used by IF/ID flush.
//  One sub-module: sat_counter #(CNT_W) (clk, rst_n, inc, count), instantiated twice.
//  FSM + cnt and the hazard compare logic live in this module.
// TESTING
//  1. ld x5 in EX, ID uses rs1=x5, defaults -> one cycle PC_write=0, bubble=1.
//     Next cycle RUN with all defaults; stall_count=1.
//  2. ld x0 in EX, ID rs1=x0 -> no stall.
//     ld x5, ID rs2=x5 but use_rs2=0 -> no stall.
//  3. LOAD_STALL_CYCLES=3, load-use -> exactly 3 bubble cycles; stall_count=3.
//     dmem_busy pulsed 2 cycles mid-stall -> freeze=1 for those cycles, total 5 cycles, count still 3.
//  4. branch_taken and load_use in the same cycle -> flush=1, bubble=1, PC_write=1; flush_count=1.
//     FLUSH_CYCLES=2 -> flush held 2 cycles.
//  5. rst_n driven low during STALL (cnt=2) -> outputs at defaults asynchronously.
//     After release: state RUN, counters 0.
//  6. CNT_W=4, 20 load-use hazards -> stall_count stops at 15 and never wraps to 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the 5-stage pipeline hazard control.
//   - hz_state_e : hazard FSM state encoding (RUN / STALL / FLUSH)
//   - REG_ZERO   : architectural zero register index (never a real dependency)
//   - NOP_INSTR  : instruction word loaded into IF/ID when it is flushed
//                  (addi x0, x0, 0)
//   - reg_match  : source/destination dependency compare helper
// -----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when the consumer actually reads a source that the producer writes.
  function automatic logic reg_match(
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic       use_rs
  );
    return use_rs && (rd == rs);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that stops at all-ones instead of wrapping.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (clears the count)
//     inc    in   count one event this cycle
//     count  out  CNT_W-bit saturating count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  // Saturation point reached: further events are ignored.
  assign w_full = &r_count;

  // Counter register; holds at all-ones once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + CNT_W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Producer-side hazard control for the 5-stage pipeline.
//   - Load-use: load in EX whose destination is read by the instruction in ID
//     -> hold PC and IF/ID, bubble ID/EX for LOAD_STALL_CYCLES cycles.
//   - Taken branch resolved in EX -> squash IF/ID and ID/EX for FLUSH_CYCLES.
//   - Data memory busy -> freeze the whole pipeline, nothing else progresses.
//   Control outputs are Mealy so a hazard is acted on in its detection cycle.
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     IDEX_MemRead, IDEX_rd         load flag / destination of EX instruction
//     IFID_rs1/rs2, IFID_use_rs1/2  sources of ID instruction and their use
//     branch_taken                  taken branch/jump resolved in EX
//     dmem_busy                     data memory not ready
//     PC_write, IFID_write          1 = PC / IF/ID may update
//     IFID_flush, IDEX_bubble       1 = IF/ID loads NOP / ID/EX control zeroed
//     pipe_freeze                   1 = EX/MEM and MEM/WB hold
//     stall_count, flush_count      saturating bubble-cycle / branch counters
// -----------------------------------------------------------------------------
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_use_rs1,
  input  logic             IFID_use_rs2,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The remaining-cycles counter only ever holds (max parameter - 1).
  localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ?
                           LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LS_RELOAD = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] FL_RELOAD = CW'(FLUSH_CYCLES - 1);

  hz_state_e       r_state;
  logic [CW-1:0]   r_cnt;

  hz_state_e       w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_load_use;
  logic            w_stall_inc;
  logic            w_flush_inc;
  logic            w_pc_write;
  logic            w_ifid_write;
  logic            w_flush;
  logic            w_bubble;
  logic            w_freeze;

  // Load-use compare; a load into x0 never creates a dependency.
  assign w_load_use = IDEX_MemRead && (IDEX_rd != REG_ZERO) &&
                      (reg_match(IDEX_rd, IFID_rs1, IFID_use_rs1) ||
                       reg_match(IDEX_rd, IFID_rs2, IFID_use_rs2));

  // Next-state, remaining-cycle and Mealy control decode.
  // Priority: dmem_busy > branch_taken > load_use / state hold.
  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;
    w_freeze     = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    if (dmem_busy) begin
      // Whole pipeline holds; FSM, cnt and counters are left untouched.
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_freeze     = 1'b1;
    end else if (branch_taken) begin
      // A taken branch wins in every state, including mid-stall, so the
      // wrong-path instruction being held in ID is squashed deterministically.
      w_flush     = 1'b1;
      w_bubble    = 1'b1;
      w_flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = HZ_FLUSH;
        w_cnt_nxt   = FL_RELOAD;
      end else begin
        w_state_nxt = HZ_RUN;
        w_cnt_nxt   = '0;
      end
    end else begin
      case (r_state)
        HZ_RUN: begin
          if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
            w_stall_inc  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              w_state_nxt = HZ_STALL;
              w_cnt_nxt   = LS_RELOAD;
            end else begin
              w_state_nxt = HZ_RUN;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_state_nxt = HZ_RUN;
            w_cnt_nxt   = '0;
          end
        end
        HZ_STALL: begin
          // Back in RUN the held ID instruction is re-evaluated for hazards.
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_bubble     = 1'b1;
          w_stall_inc  = 1'b1;
          if (r_cnt <= CNT_ONE) begin
            w_state_nxt = HZ_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end
        end
        HZ_FLUSH: begin
          // Anything in ID is wrong-path here, so load_use is not considered.
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          if (r_cnt <= CNT_ONE) begin
            w_state_nxt = HZ_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = HZ_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state and remaining-cycle counter; reset aborts any stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HZ_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Control outputs fall back to pass-through defaults while reset is held.
  always_comb begin
    if (!rst_n) begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_bubble = 1'b0;
      pipe_freeze = 1'b0;
    end else begin
      PC_write    = w_pc_write;
      IFID_write  = w_ifid_write;
      IFID_flush  = w_flush;
      IDEX_bubble = w_bubble;
      pipe_freeze = w_freeze;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit. Three instances share the stimulus:
//   sel 0 : default parameters
//   sel 1 : LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2
//   sel 2 : CNT_W=4 (saturation)
// Each stimulus cycle pushes the hand-computed expectation for one instance;
// the monitor pops and compares mid-cycle. Expected counts are the values
// visible during the cycle, i.e. before that cycle's clock edge.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic IDEX_MemRead = 1'b0;
  logic [4:0] IDEX_rd = 5'd0;
  logic [4:0] IFID_rs1 = 5'd0;
  logic [4:0] IFID_rs2 = 5'd0;
  logic IFID_use_rs1 = 1'b0;
  logic IFID_use_rs2 = 1'b0;
  logic branch_taken = 1'b0;
  logic dmem_busy = 1'b0;

  logic [4:0]  ctrl0, ctrl1, ctrl2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  // {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze}
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] STL = 5'b00010;
  localparam logic [4:0] FLS = 5'b11110;
  localparam logic [4:0] FRZ = 5'b00001;

  typedef struct {
    int          sel;
    logic [4:0]  ctrl;
    logic [15:0] sc;
    logic [15:0] fc;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit u_d0 (
    .clk(clk), .rst_n(rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .IFID_use_rs1(IFID_use_rs1),
    .IFID_use_rs2(IFID_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PC_write(ctrl0[4]), .IFID_write(ctrl0[3]), .IFID_flush(ctrl0[2]),
    .IDEX_bubble(ctrl0[1]), .pipe_freeze(ctrl0[0]),
    .stall_count(sc0), .flush_count(fc0));

  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .IFID_use_rs1(IFID_use_rs1),
    .IFID_use_rs2(IFID_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PC_write(ctrl1[4]), .IFID_write(ctrl1[3]), .IFID_flush(ctrl1[2]),
    .IDEX_bubble(ctrl1[1]), .pipe_freeze(ctrl1[0]),
    .stall_count(sc1), .flush_count(fc1));

  hazard_stall_unit #(.CNT_W(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .IFID_use_rs1(IFID_use_rs1),
    .IFID_use_rs2(IFID_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PC_write(ctrl2[4]), .IFID_write(ctrl2[3]), .IFID_flush(ctrl2[2]),
    .IDEX_bubble(ctrl2[1]), .pipe_freeze(ctrl2[0]),
    .stall_count(sc2), .flush_count(fc2));

  // Monitor: pop one expectation per cycle and compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0]  a_ctrl;
      logic [15:0] a_sc, a_fc;
      e = q.pop_front();
      case (e.sel)
        0: begin a_ctrl = ctrl0; a_sc = sc0; a_fc = fc0; end
        1: begin a_ctrl = ctrl1; a_sc = sc1; a_fc = fc1; end
        default: begin a_ctrl = ctrl2; a_sc = {12'd0, sc2}; a_fc = {12'd0, fc2}; end
      endcase
      n_checks++;
      if (a_ctrl !== e.ctrl) begin
        n_errors++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, a_ctrl, e.ctrl);
      end
      n_checks++;
      if (a_sc !== e.sc || a_fc !== e.fc) begin
        n_errors++;
        $display("FAIL %s counts: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, a_sc, a_fc, e.sc, e.fc);
      end
    end
  end

  task automatic step(input int sel, input string name, input logic rstv,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic br, input logic busy,
                      input logic [4:0] ec, input int esc, input int efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstv;
    IDEX_MemRead = mr; IDEX_rd = rd; IFID_rs1 = rs1; IFID_rs2 = rs2;
    IFID_use_rs1 = u1; IFID_use_rs2 = u2; branch_taken = br; dmem_busy = busy;
    e.sel = sel; e.ctrl = ec; e.sc = 16'(esc); e.fc = 16'(efc); e.name = name;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0;
    IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- default instance: basic load-use, no-stall cases, busy, branch ----
    do_reset();
    //   sel name        rst mr rd  rs1 rs2 u1 u2 br bz exp  sc fc
    step(0, "reset_state", 1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 0, 0);
    step(0, "t1_ld_rs1",   1, 1, 5,  5,  0,  1, 0, 0, 0, STL, 0, 0);
    step(0, "t1_after",    1, 0, 0,  5,  0,  1, 0, 0, 0, DEF, 1, 0);
    step(0, "t2_ld_x0",    1, 1, 0,  0,  0,  1, 0, 0, 0, DEF, 1, 0);
    step(0, "t2_no_use",   1, 1, 5,  3,  5,  1, 0, 0, 0, DEF, 1, 0);
    step(0, "t2_ld_rs2",   1, 1, 5,  3,  5,  1, 1, 0, 0, STL, 1, 0);
    step(0, "t2_after",    1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 2, 0);
    step(0, "busy_vs_ld",  1, 1, 7,  7,  0,  1, 0, 0, 1, FRZ, 2, 0);
    step(0, "busy_vs_br",  1, 1, 7,  7,  0,  1, 0, 1, 1, FRZ, 2, 0);
    step(0, "t4_br_ld",    1, 1, 7,  7,  0,  1, 0, 1, 0, FLS, 2, 0);
    step(0, "t4_after",    1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 2, 1);

    // ---- LOAD_STALL_CYCLES=3: three bubbles ----
    do_reset();
    step(1, "t3_c1",       1, 1, 9,  9,  0,  1, 0, 0, 0, STL, 0, 0);
    step(1, "t3_c2",       1, 1, 9,  9,  0,  1, 0, 0, 0, STL, 1, 0);
    step(1, "t3_c3",       1, 1, 9,  9,  0,  1, 0, 0, 0, STL, 2, 0);
    step(1, "t3_done",     1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 3, 0);

    // ---- stall of 3 with a 2-cycle busy pulse: 5 cycles, count 3 ----
    do_reset();
    step(1, "t3b_c1",      1, 1, 9,  0,  9,  0, 1, 0, 0, STL, 0, 0);
    step(1, "t3b_busy1",   1, 1, 9,  0,  9,  0, 1, 0, 1, FRZ, 1, 0);
    step(1, "t3b_busy2",   1, 1, 9,  0,  9,  0, 1, 0, 1, FRZ, 1, 0);
    step(1, "t3b_c2",      1, 1, 9,  0,  9,  0, 1, 0, 0, STL, 1, 0);
    step(1, "t3b_c3",      1, 1, 9,  0,  9,  0, 1, 0, 0, STL, 2, 0);
    step(1, "t3b_done",    1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 3, 0);

    // ---- FLUSH_CYCLES=2, branch beats load-use, branch during STALL ----
    do_reset();
    step(1, "t4_fl1",      1, 1, 4,  4,  0,  1, 0, 1, 0, FLS, 0, 0);
    step(1, "t4_fl2",      1, 1, 4,  4,  0,  1, 0, 0, 0, FLS, 0, 1);
    step(1, "t4_fl_done",  1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 0, 1);
    step(1, "t4_stall",    1, 1, 4,  4,  0,  1, 0, 0, 0, STL, 0, 1);
    step(1, "t4_st_br",    1, 1, 4,  4,  0,  1, 0, 1, 0, FLS, 1, 1);
    step(1, "t4_st_fl2",   1, 1, 4,  4,  0,  1, 0, 0, 0, FLS, 1, 2);
    step(1, "t4_st_done",  1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 1, 2);

    // ---- reset mid-STALL (cnt=2) ----
    do_reset();
    step(1, "t5_ld",       1, 1, 6,  6,  0,  1, 0, 0, 0, STL, 0, 0);
    step(1, "t5_rst_low",  0, 1, 6,  6,  0,  1, 0, 0, 0, DEF, 0, 0);
    step(1, "t5_released", 1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, 0, 0);
    step(1, "t5_ld_again", 1, 1, 6,  6,  0,  1, 0, 0, 0, STL, 0, 0);

    // ---- CNT_W=4 saturation over 20 hazards ----
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(2, "t6_ld",     1, 1, 8,  8,  0,  1, 0, 0, 0, STL, (i > 15) ? 15 : i, 0);
      step(2, "t6_idle",   1, 0, 0,  0,  0,  0, 0, 0, 0, DEF, (i + 1 > 15) ? 15 : i + 1, 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
